// File: rtl/lut_seq_pkg.sv
// Shared definitions for the lut_seq programmable truth-table engine.
// Optional parity storage is enabled by defining LUT_SEQ_PARITY_EN.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int IN_W_MAX  = 8;
  localparam int OUT_W_MAX = 16;

  function automatic int lut_depth(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/lut_seq_mem.sv
// Register-array table storage for lut_seq: write port, write-first read and,
// with LUT_SEQ_PARITY_EN defined, a per-entry parity bit checked on read.
module lut_seq_mem
  import lut_seq_pkg::*;
#(
  parameter int               IN_W    = 3,
  parameter int               OUT_W   = 2,
  parameter logic [OUT_W-1:0] DEF_VAL = {OUT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             par_inj,
  input  logic [IN_W-1:0]  rd_addr,
  output logic [OUT_W-1:0] rd_data,
  output logic             rd_par_err
);

  localparam int DEPTH = lut_depth(IN_W);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic             wr_hit;

  assign wr_hit = wr_en && (wr_addr == rd_addr);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= DEF_VAL;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // A read colliding with a write returns the data being written.
  assign rd_data = wr_hit ? wr_data : mem_q[rd_addr];

`ifdef LUT_SEQ_PARITY_EN
  logic par_q [DEPTH];
  logic wr_par;
  logic rd_par;

  assign wr_par = (^wr_data) ^ par_inj;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < DEPTH; k++) begin
        par_q[k] <= ^DEF_VAL;
      end
    end else if (wr_en) begin
      par_q[wr_addr] <= wr_par;
    end
  end

  assign rd_par     = wr_hit ? wr_par : par_q[rd_addr];
  assign rd_par_err = (^rd_data) != rd_par;
`else
  // Without stored parity the inject input has no effect.
  assign rd_par_err = par_inj & 1'b0;
`endif

endmodule

// File: rtl/lut_seq.sv
// Programmable 2^IN_W x OUT_W truth table with registered lookups and a
// self-sweeping streaming mode. Define LUT_SEQ_PARITY_EN for parity checking.
module lut_seq
  import lut_seq_pkg::*;
#(
  parameter int               IN_W    = 3,
  parameter int               OUT_W   = 2,
  parameter logic [OUT_W-1:0] DEF_VAL = {OUT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             lk_valid,
  input  logic [IN_W-1:0]  i,
  output logic             lk_ready,
  input  logic             sweep_start,
  output logic [OUT_W-1:0] o,
  output logic             o_valid,
  output logic [IN_W-1:0]  o_idx,
  output logic             sweep_busy,
  output logic             sweep_done,
  input  logic             par_inj,
  output logic             par_err
);

  localparam int              DEPTH = lut_depth(IN_W);
  localparam logic [IN_W-1:0] LAST  = IN_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic [IN_W-1:0]  o_idx_q, o_idx_d;
  logic             o_valid_q, o_valid_d;
  logic             done_q, done_d;
  logic             par_err_q, par_err_d;

  logic [IN_W-1:0]  rd_addr;
  logic [OUT_W-1:0] rd_data;
  logic             rd_par_err;
  logic             load;

  lut_seq_mem #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .DEF_VAL(DEF_VAL)
  ) u_mem (
    .clk       (clk),
    .rst_b     (rst_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .par_inj   (par_inj),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_par_err(rd_par_err)
  );

  // Lookups and sweep reads share the single read port; only one can be
  // active in a cycle because lookups are accepted solely in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_addr = i;
    load    = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        load = lk_valid;
        if (sweep_start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        rd_addr = cnt_q;
        load    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FLUSH;
          done_d  = 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    o_d       = load ? rd_data : o_q;
    o_idx_d   = load ? rd_addr : o_idx_q;
    o_valid_d = load;
    par_err_d = load ? rd_par_err : par_err_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_q       <= '0;
      o_idx_q   <= '0;
      o_valid_q <= 1'b0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_idx_q   <= o_idx_d;
      o_valid_q <= o_valid_d;
      done_q    <= done_d;
      par_err_q <= par_err_d;
    end
  end

  assign lk_ready   = (state_q == IDLE);
  assign sweep_busy = (state_q != IDLE);
  assign o          = o_q;
  assign o_idx      = o_idx_q;
  assign o_valid    = o_valid_q;
  assign sweep_done = done_q;
  assign par_err    = par_err_q;

endmodule

// File: tb/tb_lut_seq.sv
// Scoreboard testbench for lut_seq: a schedule-based table model predicts each
// output word; a monitor matches them as o_valid appears. Honors LUT_SEQ_PARITY_EN.
module tb_lut_seq;

  localparam int               IN_W    = 3;
  localparam int               OUT_W   = 2;
  localparam int               DEPTH   = 8;
  localparam logic [OUT_W-1:0] DEF_VAL = 2'b11;

  logic             clk = 1'b0;
  logic             rst_b = 1'b1;
  logic             wr_en = 1'b0;
  logic [IN_W-1:0]  wr_addr = '0;
  logic [OUT_W-1:0] wr_data = '0;
  logic             lk_valid = 1'b0;
  logic [IN_W-1:0]  i = '0;
  logic             lk_ready;
  logic             sweep_start = 1'b0;
  logic [OUT_W-1:0] o;
  logic             o_valid;
  logic [IN_W-1:0]  o_idx;
  logic             sweep_busy;
  logic             sweep_done;
  logic             par_inj = 1'b0;
  logic             par_err;

  lut_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .DEF_VAL(DEF_VAL)) dut (
    .clk(clk), .rst_b(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_valid(lk_valid), .i(i), .lk_ready(lk_ready), .sweep_start(sweep_start),
    .o(o), .o_valid(o_valid), .o_idx(o_idx), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .par_inj(par_inj), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               stamp;
    logic [OUT_W-1:0] val;
    logic [IN_W-1:0]  idx;
    logic             done;
    logic             perr;
  } exp_t;

  exp_t             expQ[$];
  logic [OUT_W-1:0] modelMem [DEPTH];
  logic             modelInj [DEPTH];
  int               sweepEdge = -1000;
  int               cycleCnt = 0;
  int               checks = 0;
  int               errors = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Table model: value seen by a read at an edge, honouring a same-edge write.
  function automatic exp_t modelRead(input int stamp, input logic [IN_W-1:0] a,
                                     input logic we, input logic [IN_W-1:0] wa,
                                     input logic [OUT_W-1:0] wd, input logic inj,
                                     input logic done);
    exp_t e;
    logic collide;
    collide = we && (wa == a);
    e.stamp = stamp;
    e.idx   = a;
    e.done  = done;
    e.val   = collide ? wd : modelMem[a];
`ifdef LUT_SEQ_PARITY_EN
    e.perr  = collide ? inj : modelInj[a];
`else
    e.perr  = 1'b0;
`endif
    return e;
  endfunction

  // One clock of stimulus: checks handshake status, drives inputs, predicts.
  task automatic applyStimulus(input logic we, input logic [IN_W-1:0] wa,
                               input logic [OUT_W-1:0] wd, input logic inj,
                               input logic lkv, input logic [IN_W-1:0] li,
                               input logic ss);
    int   nextEdge;
    int   k;
    logic busyNow;
    @(negedge clk);
    busyNow = (cycleCnt >= sweepEdge) && (cycleCnt <= sweepEdge + DEPTH);
    checkOutput("lk_ready", {31'd0, lk_ready}, {31'd0, !busyNow});
    checkOutput("sweep_busy", {31'd0, sweep_busy}, {31'd0, busyNow});
    wr_en = we; wr_addr = wa; wr_data = wd; par_inj = inj;
    lk_valid = lkv; i = li; sweep_start = ss;
    nextEdge = cycleCnt + 1;
    k = nextEdge - sweepEdge - 1;
    if (lkv && !busyNow)
      expQ.push_back(modelRead(nextEdge, li, we, wa, wd, inj, 1'b0));
    else if (k >= 0 && k < DEPTH)
      expQ.push_back(modelRead(nextEdge, IN_W'(k), we, wa, wd, inj, k == DEPTH - 1));
    if (ss && !busyNow) sweepEdge = nextEdge;
    if (we) begin
      modelMem[wa] = wd;
      modelInj[wa] = inj;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    wr_en = 0; lk_valid = 0; sweep_start = 0; par_inj = 0;
    #1;
    checkOutput("reset o", {30'd0, o}, 32'd0);
    checkOutput("reset o_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset o_idx", {29'd0, o_idx}, 32'd0);
    checkOutput("reset sweep_busy", {31'd0, sweep_busy}, 32'd0);
    checkOutput("reset sweep_done", {31'd0, sweep_done}, 32'd0);
    checkOutput("reset par_err", {31'd0, par_err}, 32'd0);
    checkOutput("reset lk_ready", {31'd0, lk_ready}, 32'd1);
    expQ.delete();
    for (int a = 0; a < DEPTH; a++) begin
      modelMem[a] = DEF_VAL;
      modelInj[a] = 1'b0;
    end
    sweepEdge = -1000;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Monitor: pops one prediction per o_valid and checks timing and contents.
  always @(negedge clk) begin
    if (rst_b) begin
      if (o_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected o_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("o_valid cycle", cycleCnt, e.stamp);
          checkOutput("o", {30'd0, o}, {30'd0, e.val});
          checkOutput("o_idx", {29'd0, o_idx}, {29'd0, e.idx});
          checkOutput("sweep_done", {31'd0, sweep_done}, {31'd0, e.done});
          checkOutput("par_err", {31'd0, par_err}, {31'd0, e.perr});
        end
      end else begin
        checkOutput("sweep_done idle", {31'd0, sweep_done}, 32'd0);
        if (expQ.size() > 0 && expQ[0].stamp <= cycleCnt) begin
          checkOutput("missing o_valid", 32'd0, 32'd1);
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [OUT_W-1:0] table0 [DEPTH];

  initial begin
    table0[0] = 2'b11; table0[1] = 2'b01; table0[2] = 2'b11; table0[3] = 2'b00;
    table0[4] = 2'b11; table0[5] = 2'b11; table0[6] = 2'b00; table0[7] = 2'b00;

    $display("[TB] reset and default lookup");
    applyReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd5, 0);

    $display("[TB] table programming and back-to-back lookups");
    for (int a = 0; a < DEPTH; a++) applyStimulus(1, IN_W'(a), table0[a], 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 0, 1, IN_W'(a), 0);

    $display("[TB] sweep with lookups attempted while busy");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < DEPTH + 3; n++)
      applyStimulus(0, 0, 0, 0, 1, IN_W'($urandom_range(DEPTH - 1)), 0);

    $display("[TB] lookup and sweep start together, write-first collision");
    applyStimulus(0, 0, 0, 0, 1, 3'd6, 1);
    repeat (DEPTH + 2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3'd3, 2'b10, 0, 1, 3'd3, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd3, 0);

    $display("[TB] parity inject");
    applyStimulus(1, 3'd2, 2'b01, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd2, 0);
    applyStimulus(0, 0, 0, 0, 1, 3'd1, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(99) < 40), IN_W'($urandom_range(DEPTH - 1)),
                    OUT_W'($urandom_range(3)), ($urandom_range(99) < 20),
                    ($urandom_range(99) < 60), IN_W'($urandom_range(DEPTH - 1)),
                    ($urandom_range(99) < 5));
    end
    repeat (DEPTH + 3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during sweep");
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyReset();
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 0, 1, IN_W'(a), 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_seq.md
# lut_seq

Parametrised, programmable truth-table engine: a `2^IN_W`-entry by `OUT_W`-bit table with a run-time write port. It serves registered single lookups and a self-sweeping mode that streams every entry in address order. It replaces hard-wired combinational truth tables in the exercise designs, so one block covers any input/output width and the table contents can change without a rebuild.

## Interface
- `IN_W`, 3, input/address width; legal range 1..8; `DEPTH = 1 << IN_W`
- `OUT_W`, 2, output word width; 1..16
- `DEF_VAL`, `{OUT_W{1'b1}}`, value loaded into every entry on reset
- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  IN_W  write address
- `wr_data`  in  OUT_W  write data
- `lk_valid`  in  1  lookup request
- `i`  in  IN_W  lookup address
- `lk_ready`  out  1  lookup accepted when high (`state==IDLE`)
- `sweep_start`  in  1  start full-table sweep
- `o`  out  OUT_W  registered table output
- `o_valid`  out  1  `o` valid this cycle
- `o_idx`  out  IN_W  address that produced `o`
- `sweep_busy`  out  1  sweep in progress
- `sweep_done`  out  1  one-cycle pulse with last sweep output
- `par_inj`  in  1  parity fault inject (effective only with the macro)
- `par_err`  out  1  parity mismatch on `o`

## Operation
- Reset (async, `rst_b` low): all entries = `DEF_VAL`; `o`=0, `o_valid`=0, `o_idx`=0, `sweep_busy`=0, `sweep_done`=0, `par_err`=0; FSM=IDLE, sweep counter=0. Reset mid-sweep aborts the sweep with no `sweep_done`.
- Write: on a rising edge with `wr_en`=1, `mem[wr_addr] <= wr_data`. Writes are accepted in every state.
- Read is write-first: a read of the address being written in the same cycle returns `wr_data`.
- Lookup: `lk_valid && lk_ready` at edge t loads `o=mem[i]`, `o_idx=i`, `o_valid=1` for cycle t+1. `lk_valid` while busy is dropped; there is no queueing.
- FSM:
  - IDLE: `sweep_start` goes to SWEEP with counter=0.
  - SWEEP: each cycle reads `mem[counter]` into `o` and increments the counter. When the counter equals `DEPTH-1` it goes to FLUSH.
  - FLUSH: goes to IDLE.
- `sweep_busy` = (state≠IDLE). `sweep_start` while busy is ignored.
- `lk_valid` and `sweep_start` in the same IDLE cycle: both are accepted. The lookup result appears at t+1; sweep outputs begin at t+2.
- Counter is exactly IN_W bits and wraps to 0 after `DEPTH-1`. There is no overflow logic.

## Timing
- Lookup latency: 1 cycle. Throughput: 1 lookup per cycle while IDLE.
- Sweep with `sweep_start` at edge t: outputs for idx 0..DEPTH-1 appear on consecutive cycles t+2 .. t+1+DEPTH, each with `o_valid`=1.
- `sweep_done`=1 only in cycle t+1+DEPTH, together with idx DEPTH-1.
- `sweep_busy` is high for cycles t+1 .. t+1+DEPTH; `lk_ready` returns high at t+2+DEPTH.
- A write during a sweep to an address not yet read is visible in the sweep output.

## Configuration
- `LUT_SEQ_PARITY_EN` defined:
  - Each entry stores an extra bit, `^wr_data ^ par_inj`. Reset value is `^DEF_VAL`.
  - `par_err` is registered alongside `o` and equals (`^o` ≠ stored bit).
- `LUT_SEQ_PARITY_EN` undefined:
  - No parity storage.
  - `par_err` tied 0 and `par_inj` ignored.
  - Ports are identical in both builds.

## Structure
- `lut_seq_pkg` holds the FSM state encoding (IDLE=2'd0, SWEEP=2'd1, FLUSH=2'd2) and the `DEPTH` computation helper.
- One sub-module, `lut_seq_mem`: the async-reset register array with the write port, the write-first read mux and the optional parity bit.
- The FSM and output registers stay in the top level.

## Test plan
- Reset, no writes, lookup i=5 → next cycle `o`=2'b11, `o_idx`=5, `o_valid`=1; all other outputs 0 before the lookup.
- Write {0:11, 1:01, 2:11, 3:00, 4:11, 5:11, 6:00, 7:00}, then lookups 0..7 back-to-back → outputs match, one per cycle, latency 1.
- `sweep_start` pulse → 8 consecutive `o_valid` cycles with `o_idx` 0..7 and the table above. `sweep_done` only with idx 7. `lk_valid` during the sweep is ignored and `lk_ready`=0.
- Same-cycle write addr 3 data 10 and lookup i=3 → `o`=2'b10 (write-first).
- `rst_b` low at sweep idx 4 → outputs zero immediately, no `sweep_done`, table back to 2'b11 everywhere.
- With `LUT_SEQ_PARITY_EN`: write addr 2 with `par_inj`=1, lookup 2 → `par_err`=1; lookup 1 → `par_err`=0. Without the macro, `par_err` stays 0.
